// File: rtl/uart_rx_deserialiser_if.sv
// Byte-side and line-side signals of the 8N1 UART receiver.
// master: the environment that drives the serial line and enable and
//         consumes the received bytes.
// slave:  the receiver itself.
interface uart_rx_deserialiser_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx_deserialiser.sv
// 8N1 UART receive front end. The asynchronous line is synchronised, a
// falling edge starts a frame, the start bit is re-checked at its middle and
// each following bit is sampled one bit period later. Good frames produce a
// one-cycle valid pulse; a low stop bit produces a one-cycle framing-error or
// break pulse, after which the line must return high before a new frame.
module uart_rx_deserialiser #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_deserialiser_if.slave  rx
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned CW             = $clog2(CYCLES_PER_BIT) + 1;
  localparam int unsigned IW             = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BITS - 1);

  if (CYCLES_PER_BIT < 4) begin : g_rate_check
    $error("uart_rx_deserialiser: CLK_HZ/BIT_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                  r_state;
  logic                    r_rxd_meta;
  logic                    r_rxs;
  logic                    r_rxs_prev;
  logic [2:0]              r_fill;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_valid;
  logic                    r_frame_err;
  logic                    r_break;

  logic                    w_fall;
  logic [CW-1:0]           w_cnt_inc;

  // The reset value of the synchroniser is 1, so a line that is already low
  // when reset is released would look like a falling edge. r_fill marks when
  // both rxs and its previous value come from the real line, and edges are
  // ignored until then.
  assign w_fall    = r_fill[2] & r_rxs_prev & ~r_rxs;
  assign w_cnt_inc = r_cnt + 1'b1;

  assign rx.uart_rx_valid     = r_valid;
  assign rx.uart_rx_data      = r_data;
  assign rx.uart_rx_frame_err = r_frame_err;
  assign rx.uart_rx_break     = r_break;

  // Two-flop synchroniser plus previous-sample register; keeps running in
  // every state so a start edge late in the stop bit is still seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_fill     <= '0;
    end else begin
      r_rxd_meta <= rx.uart_rxd;
      r_rxs      <= r_rxd_meta;
      r_rxs_prev <= r_rxs;
      r_fill     <= {r_fill[1:0], 1'b1};
    end
  end

  // Frame state machine with bit timing, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;

      if (!rx.uart_rx_en && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (rx.uart_rx_en && w_fall) begin
              r_state <= S_START;
            end
          end

          S_START: begin
            if (r_cnt == HALF_LAST) begin
              r_cnt <= '0;
              if (!r_rxs) begin
                r_state <= S_DATA;
                r_idx   <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          S_DATA: begin
            if (r_cnt == BIT_LAST) begin
              r_cnt          <= '0;
              r_shift[r_idx] <= r_rxs;
              if (r_idx == IDX_LAST) begin
                r_state <= S_STOP;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          S_STOP: begin
            if (r_cnt == BIT_LAST) begin
              r_cnt <= '0;
              if (r_rxs) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                if (r_shift != '0) begin
                  r_frame_err <= 1'b1;
                end else begin
                  r_break <= 1'b1;
                end
                r_state <= S_WAIT_HIGH;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          S_WAIT_HIGH: begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserialiser.sv
// Directed bench for uart_rx_deserialiser at 32 clocks per bit.
module tb_uart_rx_deserialiser;

  localparam int unsigned CLK_HZ   = 100000000;
  localparam int unsigned BIT_RATE = 3125000;
  localparam int          CPB      = 32;

  logic clk;
  logic reset;
  int   cyc;

  int n_pass;
  int n_total;

  int n_valid;
  int n_ferr;
  int n_brk;
  int n_multi;
  int last_valid_cyc;
  int start_cyc;
  logic [7:0] rx_q[$];

  uart_rx_deserialiser_if #(.PAYLOAD_BITS(8)) u_if ();

  uart_rx_deserialiser #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(8)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .rx   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the falling edge: counts pulses and logs received bytes.
  initial begin
    n_valid = 0; n_ferr = 0; n_brk = 0; n_multi = 0; last_valid_cyc = 0;
  end
  always @(negedge clk) begin
    if (u_if.uart_rx_valid === 1'b1) begin
      n_valid++;
      rx_q.push_back(u_if.uart_rx_data);
      last_valid_cyc = cyc;
    end
    if (u_if.uart_rx_frame_err === 1'b1) n_ferr++;
    if (u_if.uart_rx_break === 1'b1) n_brk++;
    if ((32'(u_if.uart_rx_valid) + 32'(u_if.uart_rx_frame_err) + 32'(u_if.uart_rx_break)) > 1)
      n_multi++;
  end

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic v);
    u_if.uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #2;
  endtask

  // One 8N1 frame; stop_low_bits low bit periods are inserted before the
  // high stop bit to create a framing error.
  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    align();
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    for (int i = 0; i < stop_low_bits; i++) drive_bit(1'b0);
    drive_bit(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.uart_rxd = 1'b1;
    u_if.uart_rx_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (u_if.uart_rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", u_if.uart_rx_data);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", u_if.uart_rx_valid);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", u_if.uart_rx_frame_err);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_break !== 1'b0) $display("FAIL reset_break: got %b want 0", u_if.uart_rx_break);
    else n_pass++;
    align();
    reset = 1'b0;
    idle_bits(2);
    n_total++;
    if ((n_valid + n_ferr + n_brk) !== 0) $display("FAIL reset_idle_pulses: got %0d want 0", n_valid + n_ferr + n_brk);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    int v0, e0, ideal, dt;
    v0 = n_valid; e0 = n_ferr + n_brk;
    rx_q.delete();
    send_frame(8'h41, 0);
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 1) $display("FAIL single_valid_count: got %0d want 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h41) $display("FAIL single_data: got %h want 41", u_if.uart_rx_data);
    else n_pass++;
    n_total++;
    if ((n_ferr + n_brk - e0) !== 0) $display("FAIL single_errors: got %0d want 0", n_ferr + n_brk - e0);
    else n_pass++;
    // Ideal point: 2 synchroniser cycles plus 9.5 bit periods after the start edge.
    ideal = 2 + (19 * CPB) / 2;
    dt = last_valid_cyc - start_cyc;
    n_total++;
    if (dt < ideal - CPB || dt > ideal + CPB)
      $display("FAIL single_latency: got %0d cycles want %0d +/- %0d", dt, ideal, CPB);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[9];
    logic [7:0] got;
    int v0, e0;
    msg = '{8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33, 8'h44, 8'h34, 8'h00};
    v0 = n_valid; e0 = n_ferr + n_brk;
    rx_q.delete();
    for (int i = 0; i < 9; i++) begin
      send_frame(msg[i], 0);
      repeat (100) @(posedge clk);
    end
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 9) $display("FAIL b2b_valid_count: got %0d want 9", n_valid - v0);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++;
      if (got !== msg[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got, msg[i]);
      else n_pass++;
    end
    n_total++;
    if ((n_ferr + n_brk - e0) !== 0) $display("FAIL b2b_errors: got %0d want 0", n_ferr + n_brk - e0);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_brk;
    send_frame(8'h61, 1);
    idle_bits(2);
    n_total++;
    if ((n_ferr - f0) !== 1) $display("FAIL ferr_count: got %0d want 1", n_ferr - f0);
    else n_pass++;
    n_total++;
    if ((n_valid - v0) !== 0) $display("FAIL ferr_valid_count: got %0d want 0", n_valid - v0);
    else n_pass++;
    n_total++;
    if ((n_brk - b0) !== 0) $display("FAIL ferr_break_count: got %0d want 0", n_brk - b0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h00) $display("FAIL ferr_data_held: got %h want 00", u_if.uart_rx_data);
    else n_pass++;
    send_frame(8'h62, 0);
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 1) $display("FAIL ferr_next_valid: got %0d want 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h62) $display("FAIL ferr_next_data: got %h want 62", u_if.uart_rx_data);
    else n_pass++;
  endtask

  task automatic test_break();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_brk;
    align();
    u_if.uart_rxd = 1'b0;
    idle_bits(20);
    u_if.uart_rxd = 1'b1;
    idle_bits(3);
    n_total++;
    if ((n_brk - b0) !== 1) $display("FAIL break_count: got %0d want 1", n_brk - b0);
    else n_pass++;
    n_total++;
    if ((n_valid - v0) !== 0) $display("FAIL break_valid_count: got %0d want 0", n_valid - v0);
    else n_pass++;
    n_total++;
    if ((n_ferr - f0) !== 0) $display("FAIL break_ferr_count: got %0d want 0", n_ferr - f0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h62) $display("FAIL break_data_held: got %h want 62", u_if.uart_rx_data);
    else n_pass++;
    send_frame(8'h63, 0);
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 1) $display("FAIL break_next_valid: got %0d want 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h63) $display("FAIL break_next_data: got %h want 63", u_if.uart_rx_data);
    else n_pass++;
  endtask

  task automatic test_false_start_enable();
    int p0, v0;
    logic [7:0] b;
    b = 8'h64;
    // Glitch shorter than half a bit period.
    p0 = n_valid + n_ferr + n_brk;
    align();
    u_if.uart_rxd = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    u_if.uart_rxd = 1'b1;
    idle_bits(12);
    n_total++;
    if ((n_valid + n_ferr + n_brk - p0) !== 0) $display("FAIL glitch_pulses: got %0d want 0", n_valid + n_ferr + n_brk - p0);
    else n_pass++;
    // Whole frame with the receiver disabled.
    p0 = n_valid + n_ferr + n_brk;
    u_if.uart_rx_en = 1'b0;
    send_frame(b, 0);
    idle_bits(1);
    u_if.uart_rx_en = 1'b1;
    idle_bits(2);
    n_total++;
    if ((n_valid + n_ferr + n_brk - p0) !== 0) $display("FAIL disabled_pulses: got %0d want 0", n_valid + n_ferr + n_brk - p0);
    else n_pass++;
    // Enable dropped at data bit 4 and held low to the end of the frame.
    p0 = n_valid + n_ferr + n_brk;
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) u_if.uart_rx_en = 1'b0;
      drive_bit(b[i]);
    end
    drive_bit(1'b1);
    u_if.uart_rx_en = 1'b1;
    idle_bits(3);
    n_total++;
    if ((n_valid + n_ferr + n_brk - p0) !== 0) $display("FAIL abort_pulses: got %0d want 0", n_valid + n_ferr + n_brk - p0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'h63) $display("FAIL abort_data_held: got %h want 63", u_if.uart_rx_data);
    else n_pass++;
    v0 = n_valid;
    send_frame(8'h64, 0);
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 1 || u_if.uart_rx_data !== 8'h64)
      $display("FAIL enable_recover: got count %0d data %h want count 1 data 64", n_valid - v0, u_if.uart_rx_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int p0, v0;
    logic [7:0] b;
    b = 8'h55;
    p0 = n_valid + n_ferr + n_brk;
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    // Data bit 3 is low; reset lands a quarter of the way into it.
    u_if.uart_rxd = b[3];
    repeat (CPB / 4) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (u_if.uart_rx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", u_if.uart_rx_data);
    else n_pass++;
    n_total++;
    if ({u_if.uart_rx_valid, u_if.uart_rx_frame_err, u_if.uart_rx_break} !== 3'b000)
      $display("FAIL rstmid_flags: got %b want 000", {u_if.uart_rx_valid, u_if.uart_rx_frame_err, u_if.uart_rx_break});
    else n_pass++;
    // The line stays low through the rest of bit 3, then the sender gives up
    // and leaves it idle; no frame may start from the already-low line.
    repeat (CPB - CPB / 4 - 2) @(posedge clk);
    #2;
    u_if.uart_rxd = 1'b1;
    idle_bits(12);
    n_total++;
    if ((n_valid + n_ferr + n_brk - p0) !== 0) $display("FAIL rstmid_pulses: got %0d want 0", n_valid + n_ferr + n_brk - p0);
    else n_pass++;
    v0 = n_valid;
    send_frame(8'hA5, 0);
    idle_bits(2);
    n_total++;
    if ((n_valid - v0) !== 1) $display("FAIL rstmid_next_valid: got %0d want 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (u_if.uart_rx_data !== 8'hA5) $display("FAIL rstmid_next_data: got %h want a5", u_if.uart_rx_data);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_err();
    test_break();
    test_false_start_enable();
    test_reset_mid_frame();
    n_total++;
    if (n_multi !== 0) $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", n_multi);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
